// File: rtl/pwla_neuron_mac.sv
// -----------------------------------------------------------------------------
// pwla_neuron_mac
//
// Serial multiply-accumulate stage feeding the PWL sigmoid. One evaluation:
// capture the bias on start, accumulate N_INPUTS activation*weight products
// (one per in_valid/in_ready handshake), round half-up back to Q5.10, saturate
// to 16 bits and hold the result on a valid/ready output until it is consumed.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      begin an evaluation (sampled only while idle)
//   bias       signed Q5.10 bias, captured with start
//   in_valid   in_x/in_w pair is valid
//   in_ready   block accepts a pair this cycle (registered)
//   in_x       signed Q5.10 activation
//   in_w       signed Q5.10 weight
//   out_valid  out_x holds a finished result (registered)
//   out_ready  downstream accepts the result
//   out_x      signed Q5.10 rounded/saturated weighted sum (registered)
//   out_sat    out_x was clipped; meaningful while out_valid=1 (registered)
//   busy       an evaluation is in progress or a result is pending
// -----------------------------------------------------------------------------
module pwla_neuron_mac #(
    parameter int N_INPUTS = 8,
    parameter int FRAC     = 10,
    parameter int ACC_W    = 40
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic signed [15:0] bias,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] in_x,
    input  logic signed [15:0] in_w,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] out_x,
    output logic               out_sat,
    output logic               busy
);

    // Wide enough to hold the value N_INPUTS itself.
    localparam int CNT_W = $clog2(N_INPUTS + 1);

    localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(2 ** (FRAC - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX    = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN    = ACC_W'(-32768);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ROUND,
        HOLD
    } state_t;

    state_t state, state_next;

    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        count;

    logic                    in_fire;
    logic                    out_fire;
    logic                    last_pair;
    logic signed [31:0]      product;
    logic signed [ACC_W-1:0] product_ext;
    logic signed [ACC_W-1:0] bias_acc;
    logic signed [ACC_W-1:0] rounded;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign last_pair = in_fire && (count == CNT_W'(N_INPUTS - 1));

    // Size casts of signed operands sign-extend, so the 32-bit product is exact.
    assign product     = 32'(in_x) * 32'(in_w);
    assign product_ext = ACC_W'(product);
    // Bias moves from Q5.10 to the Q.20 scale of the products.
    assign bias_acc    = ACC_W'(bias) <<< FRAC;
    // Round half-up: add half an output LSB, then floor via arithmetic shift.
    assign rounded     = (acc + ROUND_HALF) >>> FRAC;

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            // NOTE: flops are always written with <= so every process sees the
            // pre-edge value of every other flop, independent of process order.
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: assigning the default before the case keeps every path covered,
        // so no latch is inferred when a branch leaves the state unchanged.
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = ACCUM;
            ACCUM:   if (last_pair) state_next = ROUND;
            ROUND:                  state_next = HOLD;
            HOLD:    if (out_fire)  state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the accumulator and counter are reset too, so a partial sum
            // cut short by reset can never leak into a later evaluation.
            acc       <= '0;
            count     <= '0;
            in_ready  <= 1'b0;
            out_x     <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= bias_acc;
                        count    <= '0;
                        in_ready <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (in_fire) begin
                        acc   <= acc + product_ext;
                        count <= count + 1'b1;
                        if (last_pair) begin
                            in_ready <= 1'b0;
                        end
                    end
                end
                ROUND: begin
                    if (rounded > SAT_MAX) begin
                        out_x   <= 16'sh7fff;
                        out_sat <= 1'b1;
                    end else if (rounded < SAT_MIN) begin
                        out_x   <= 16'sh8000;
                        out_sat <= 1'b1;
                    end else begin
                        out_x   <= rounded[15:0];
                        out_sat <= 1'b0;
                    end
                    out_valid <= 1'b1;
                end
                HOLD: begin
                    if (out_fire) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pwla_neuron_mac.sv
// -----------------------------------------------------------------------------
// tb_pwla_neuron_mac
//
// Self-checking bench for pwla_neuron_mac. Directed and random evaluations are
// compared against a reference model that works in plain 64-bit arithmetic:
// exact real-valued weighted sum, round half-up by floor division, clamp.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pwla_neuron_mac;

    localparam int N = 8;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start;
    logic signed [15:0] bias;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_x;
    logic signed [15:0] in_w;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_x;
    logic               out_sat;
    logic               busy;

    int tests = 0;
    int fails = 0;
    int xs[N];
    int ws[N];

    pwla_neuron_mac #(.N_INPUTS(N), .FRAC(10), .ACC_W(40)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: value = bias + sum(x*w) in real units; result in LSBs of 1/1024.
    function automatic void model(input int b, output int ex, output int es);
        longint s;
        longint q;
        s = longint'(b) * 1024;
        for (int i = 0; i < N; i++) s += longint'(xs[i]) * longint'(ws[i]);
        s += 512;
        q = s / 1024;
        if ((s % 1024 != 0) && (s < 0)) q -= 1;   // floor toward -inf
        if (q > 32767) begin
            ex = 32767;  es = 1;
        end else if (q < -32768) begin
            ex = -32768; es = 1;
        end else begin
            ex = int'(q); es = 0;
        end
    endfunction

    task automatic start_eval(input int b);
        start = 1'b1;
        bias  = 16'(b);
        @(negedge clk);
        start = 1'b0;
        check("start_in_ready", {31'd0, in_ready}, 1);
        check("start_busy", {31'd0, busy}, 1);
    endtask

    task automatic send_pair(input int x, input int w, input int gap_max);
        int g;
        int guard;
        g = (gap_max > 0) ? int'($urandom_range(gap_max)) : 0;
        in_valid = 1'b0;
        repeat (g) @(negedge clk);
        if (g > 0) begin
            check("stall_in_ready", {31'd0, in_ready}, 1);
            check("stall_out_valid", {31'd0, out_valid}, 0);
        end
        in_valid = 1'b1;
        in_x     = 16'(x);
        in_w     = 16'(w);
        guard    = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("pair_accept_timeout", {31'd0, in_ready}, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called in the cycle after the last pair was accepted (the rounding cycle).
    task automatic finish_eval(input string tag, input int b, output int got);
        int ex;
        int es;
        model(b, ex, es);
        check({tag, "_round_out_valid"}, {31'd0, out_valid}, 0);
        check({tag, "_round_in_ready"}, {31'd0, in_ready}, 0);
        @(negedge clk);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 1);
        check({tag, "_out_x"}, 32'(out_x), ex);
        check({tag, "_out_sat"}, {31'd0, out_sat}, es);
        got = int'(out_x);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_consumed_valid"}, {31'd0, out_valid}, 0);
        check({tag, "_consumed_busy"}, {31'd0, busy}, 0);
    endtask

    task automatic run_eval(input string tag, input int b, input int gap_max,
                            output int got);
        start_eval(b);
        for (int i = 0; i < N; i++) send_pair(xs[i], ws[i], gap_max);
        finish_eval(tag, b, got);
    endtask

    task automatic fill(input int x, input int w);
        for (int i = 0; i < N; i++) begin
            xs[i] = x;
            ws[i] = w;
        end
    endtask

    initial begin
        int got;
        int got_stall;
        int rb;
        logic signed [15:0] held_x;
        logic               held_sat;

        reset_n   = 1'b0;
        start     = 1'b0;
        bias      = '0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_w      = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_out_x", 32'(out_x), 0);
        check("rst_out_sat", {31'd0, out_sat}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of accumulation discards the partial sum.
        fill(1024, 1024);
        start_eval(100);
        for (int i = 0; i < 3; i++) send_pair(2000, 2000, 0);
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 0);
        check("midrst_in_ready", {31'd0, in_ready}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_eval("after_rst", 0, 0, got);

        // Basic signed sum: 4.0 - 4.0 + 0.5.
        for (int i = 0; i < N; i++) begin
            xs[i] = (i < 4) ? 1024 : -2048;
            ws[i] = (i < 4) ? 1024 : 512;
        end
        run_eval("basic", 512, 0, got);

        // Rounding: +0.5 LSB up, -0.5 LSB to zero, -1.5 LSB to -1.
        fill(0, 0); xs[0] = 1;  ws[0] = 512;
        run_eval("round_pos_half", 0, 0, got);
        fill(0, 0); xs[0] = -1; ws[0] = 512;
        run_eval("round_neg_half", 0, 0, got);
        fill(0, 0); xs[0] = -3; ws[0] = 512;
        run_eval("round_neg_1p5", 0, 0, got);

        // Saturation in both directions.
        fill(32767, 32767);
        run_eval("sat_hi", 0, 0, got);
        fill(-32768, 32767);
        run_eval("sat_lo", 0, 0, got);

        // Random vectors, each run stall-free and then with random input gaps.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) begin
                if (t < 3) begin
                    xs[i] = int'($urandom_range(4095)) - 2048;
                    ws[i] = int'($urandom_range(4095)) - 2048;
                end else begin
                    xs[i] = int'($urandom_range(65535)) - 32768;
                    ws[i] = int'($urandom_range(65535)) - 32768;
                end
            end
            rb = int'($urandom_range(65535)) - 32768;
            run_eval("rand_nostall", rb, 0, got);
            run_eval("rand_stall", rb, 5, got_stall);
            check("rand_stall_vs_nostall", got_stall, got);
        end

        // Backpressure: result held while start and in_valid are pulsed.
        fill(0, 0); xs[2] = 3000; ws[2] = -700;
        start_eval(-300);
        for (int i = 0; i < N; i++) send_pair(xs[i], ws[i], 0);
        @(negedge clk);
        held_x   = out_x;
        held_sat = out_sat;
        model(-300, rb, got);
        check("bp_out_x_initial", 32'(held_x), rb);
        for (int c = 0; c < 6; c++) begin
            start    = 1'b1;
            in_valid = 1'($urandom_range(1));
            in_x     = 16'($urandom);
            in_w     = 16'($urandom);
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid}, 1);
            check("bp_out_x_stable", 32'(out_x), 32'(held_x));
            check("bp_out_sat_stable", {31'd0, out_sat}, {31'd0, held_sat});
            check("bp_in_ready", {31'd0, in_ready}, 0);
        end
        in_valid  = 1'b0;
        start     = 1'b1;   // coincides with the output handshake: ignored
        out_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        check("bp_release_valid", {31'd0, out_valid}, 0);
        check("bp_release_busy", {31'd0, busy}, 0);
        @(negedge clk);
        check("bp_idle_busy", {31'd0, busy}, 0);
        check("bp_idle_in_ready", {31'd0, in_ready}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
